// File: rtl/spi_segment_scanner.sv
// SPI-slave controller for a time-multiplexed DIGITS-wide 7-segment display.
// Frames are 16 bits {cmd, addr, data}; each one is decoded when chip select rises.
module spi_segment_scanner #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 10_000,
  parameter int BLINK_DIV = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] dig_en,
  output logic              frame_err
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SLOT_W  = $clog2(SCAN_DIV);
  localparam int FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [3:0] CMD_RAW   = 4'h1;
  localparam logic [3:0] CMD_HEX   = 4'h2;
  localparam logic [3:0] CMD_BLINK = 4'h3;
  localparam logic [3:0] CMD_CTRL  = 4'h4;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_DIV - 1);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Synchronisers plus one extra stage on SCK and CS for edge detection.
  logic [1:0] sck_sync, cs_sync, mosi_sync;
  logic       sck_prev, cs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_prev  <= sck_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, cs_fall, cs_rise;

  assign sck_s    = sck_sync[1];
  assign cs_s     = cs_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sck_rise = sck_s & ~sck_prev;
  assign cs_fall  = ~cs_s & cs_prev;
  assign cs_rise  = cs_s & ~cs_prev;

  logic [15:0] shreg;
  logic [4:0]  bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (cs_fall) begin
      bit_cnt <= '0;
    end else if (sck_rise && !cs_s) begin
      shreg <= {shreg[14:0], mosi_s};
      if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  logic [3:0]       cmd, addr;
  logic [7:0]       data;
  logic             wr_digit, wr_blink, wr_ctrl, set_err;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_val;

  assign cmd  = shreg[15:12];
  assign addr = shreg[11:8];
  assign data = shreg[7:0];

  always_comb begin
    wr_digit = 1'b0;
    wr_blink = 1'b0;
    wr_ctrl  = 1'b0;
    set_err  = 1'b0;
    wr_idx   = '0;
    wr_val   = '0;
    if (cs_rise) begin
      if (bit_cnt != 5'd16) begin
        set_err = 1'b1;
      end else begin
        case (cmd)
          CMD_RAW, CMD_HEX: begin
            if (int'(addr) < DIGITS) begin
              wr_digit = 1'b1;
              wr_idx   = addr[IDX_W-1:0];
              wr_val   = (cmd == CMD_RAW) ? data : {data[4], hex7(data[3:0])};
            end else begin
              set_err = 1'b1;
            end
          end
          CMD_BLINK: wr_blink = 1'b1;
          CMD_CTRL:  wr_ctrl  = 1'b1;
          default:   set_err  = 1'b1;
        endcase
      end
    end
  end

  logic [7:0]        digit [DIGITS];
  logic [DIGITS-1:0] blink_mask;
  logic              enable, test;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) digit[i] <= 8'h00;
      blink_mask <= '0;
      enable     <= 1'b1;
      test       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (wr_digit) digit[wr_idx] <= wr_val;
      if (wr_blink) blink_mask <= data[DIGITS-1:0];
      if (wr_ctrl) begin
        enable    <= data[0];
        test      <= data[1];
        frame_err <= 1'b0;
      end else if (set_err) begin
        frame_err <= 1'b1;
      end
    end
  end

  logic [SLOT_W-1:0]  slot_cnt;
  logic [IDX_W-1:0]   dig_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_ph;
  logic               slot_wrap, dig_wrap;

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign dig_wrap  = slot_wrap && (dig_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      dig_idx   <= '0;
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap) dig_idx <= dig_wrap ? '0 : dig_idx + 1'b1;
      if (dig_wrap) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Slot 0 of every digit is blanked on both segments and enables to avoid ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= 8'h00;
      dig_en  <= '0;
    end else if (slot_cnt == '0) begin
      seg_out <= 8'h00;
      dig_en  <= '0;
    end else begin
      dig_en <= DIGITS'(1) << dig_idx;
      if (!enable)                            seg_out <= 8'h00;
      else if (test)                          seg_out <= 8'hFF;
      else if (blink_mask[dig_idx] && blink_ph) seg_out <= 8'h00;
      else                                    seg_out <= digit[dig_idx];
    end
  end

endmodule
